// File: rtl/exp_golomb_parse_ctrl_if.sv
// Request/bitstream/decoder/response bundle for the shared Exp-Golomb sequencer.
// The slave side is the sequencer; the master side is the parser/buffer/decoder environment.
interface exp_golomb_parse_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_sel;
   logic [4:0]  req_tag;
   logic [15:0] bs_window;
   logic [4:0]  bs_avail;
   logic        bs_consume;
   logic [4:0]  bs_consume_len;
   logic [1:0]  dec_sel;
   logic [3:0]  dec_heading_one_pos;
   logic [7:0]  dec_output;
   logic [4:0]  dec_len;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [4:0]  rsp_tag;
   logic        rsp_err;
   logic        busy;

   modport slave (
      input  req_valid, req_sel, req_tag, bs_window, bs_avail, dec_output, dec_len,
      output req_ready, bs_consume, bs_consume_len, dec_sel, dec_heading_one_pos,
             rsp_valid, rsp_data, rsp_tag, rsp_err, busy
   );

   modport master (
      output req_valid, req_sel, req_tag, bs_window, bs_avail, dec_output, dec_len,
      input  req_ready, bs_consume, bs_consume_len, dec_sel, dec_heading_one_pos,
             rsp_valid, rsp_data, rsp_tag, rsp_err, busy
   );
endinterface

// File: rtl/exp_golomb_parse_ctrl.sv
// Shares one Exp-Golomb decoder among the header parsers: scans the leading-zero run,
// waits for enough bits, drives the decoder, then responds and consumes the codeword.
module exp_golomb_parse_ctrl #(
   parameter int unsigned MAX_STALL = 63
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   exp_golomb_parse_ctrl_if.slave      bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_DECODE,
      S_CONSUME,
      S_ERR
   } state_t;

   localparam logic [7:0] LP_MAX_STALL = 8'(MAX_STALL);

   state_t      r_state;
   state_t      w_nxt;

   logic [1:0]  r_sel;
   logic [4:0]  r_tag;
   logic [2:0]  r_pos;
   logic [7:0]  r_stall;

   logic        r_req_ready;
   logic        r_busy;
   logic        r_consume;
   logic [4:0]  r_consume_len;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [7:0]  r_rsp_data;

   logic [4:0]  w_lz;
   logic [4:0]  w_need;
   logic        w_win_bad;
   logic        w_short;
   logic        w_sel_ok;
   logic [4:0]  w_cw_len;

   // Ascending loop lets the highest set bit win; an all-zero window leaves lz=16.
   always_comb begin
      w_lz = 5'd16;
      for (int i = 0; i < 16; i++) begin
         if (bus.bs_window[i]) w_lz = 5'(15 - i);
      end
   end

   assign w_win_bad = (w_lz > 5'd7);
   assign w_need    = {w_lz[3:0], 1'b1};
   assign w_short   = (bus.bs_avail < w_need);
   assign w_sel_ok  = (bus.req_sel == 2'b01) || (bus.req_sel == 2'b10);
   assign w_cw_len  = {1'b0, r_pos, 1'b1};

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) w_nxt = w_sel_ok ? S_SCAN : S_ERR;
         end
         S_SCAN: begin
            if (w_win_bad)                   w_nxt = S_ERR;
            else if (!w_short)               w_nxt = S_DECODE;
            else if (r_stall == LP_MAX_STALL) w_nxt = S_ERR;
         end
         S_DECODE: begin
            w_nxt = (bus.dec_len != w_cw_len) ? S_ERR : S_CONSUME;
         end
         S_CONSUME: w_nxt = S_IDLE;
         S_ERR:     w_nxt = S_IDLE;
         default:   w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_sel         <= 2'b00;
         r_tag         <= 5'd0;
         r_pos         <= 3'd0;
         r_stall       <= 8'd0;
         r_req_ready   <= 1'b1;
         r_busy        <= 1'b0;
         r_consume     <= 1'b0;
         r_consume_len <= 5'd0;
         r_rsp_valid   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_data    <= 8'd0;
      end else begin
         r_state       <= w_nxt;
         // Registered outputs are loaded from the next state so they line up with it.
         r_req_ready   <= (w_nxt == S_IDLE);
         r_busy        <= (w_nxt != S_IDLE);
         r_consume     <= (w_nxt == S_CONSUME);
         r_consume_len <= (w_nxt == S_CONSUME) ? w_cw_len : 5'd0;
         r_rsp_valid   <= (w_nxt == S_CONSUME) || (w_nxt == S_ERR);
         r_rsp_err     <= (w_nxt == S_ERR);
         r_rsp_data    <= (w_nxt == S_CONSUME) ? bus.dec_output : 8'd0;

         if (r_state == S_IDLE && bus.req_valid) begin
            r_sel   <= bus.req_sel;
            r_tag   <= bus.req_tag;
            r_stall <= 8'd0;
         end

         if (r_state == S_SCAN && !w_win_bad) begin
            if (!w_short) r_pos   <= w_lz[2:0];
            else          r_stall <= r_stall + 8'd1;
         end
      end
   end

   assign bus.req_ready           = r_req_ready;
   assign bus.busy                = r_busy;
   assign bus.bs_consume          = r_consume;
   assign bus.bs_consume_len      = r_consume_len;
   assign bus.rsp_valid           = r_rsp_valid;
   assign bus.rsp_err             = r_rsp_err;
   assign bus.rsp_data            = r_rsp_data;
   assign bus.rsp_tag             = r_tag;
   assign bus.dec_sel             = (r_state == S_DECODE) ? r_sel : 2'b00;
   assign bus.dec_heading_one_pos = (r_state == S_DECODE) ? {1'b0, r_pos} : 4'd0;

endmodule

// File: doc/exp_golomb_parse_ctrl.md
# exp_golomb_parse_ctrl

Sequencer that shares the Exp-Golomb decoder between the SPS, PPS, slice-header and dec_ref_pic_marking parsers. It accepts one ue(v)/se(v) decode request at a time and finds the leading-one position in the 16-bit bitstream window. It waits until enough bits are valid, drives the decoder, and returns the result. It then issues a single consume pulse, with the codeword length, to the bitstream buffer.

## Interface
Parameters:
- MAX_STALL, 63: maximum number of cycles spent waiting for bits before an error is flagged (1..255).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  decode request.
- req_ready  out  1  high only in IDLE.
- req_sel  in  2  01 = ue, 10 = se; 00 and 11 are illegal.
- req_tag  in  5  requester/syntax-element tag, echoed on the response.
- bs_window  in  16  bitstream window, next bit at [15]; held stable unless bs_consume fires.
- bs_avail  in  5  number of valid bits in the window (0..16).
- bs_consume  out  1  one-cycle pulse: the buffer advances by bs_consume_len.
- bs_consume_len  out  5  codeword length; 0 when bs_consume is low.
- dec_sel  out  2  decoder select (ue/se); 00 except in DECODE.
- dec_heading_one_pos  out  4  leading-zero count passed to the decoder.
- dec_output  in  8  decoder result (combinational).
- dec_len  in  5  decoder length (combinational).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  8  decoded value (two's complement for se).
- rsp_tag  out  5  captured req_tag.
- rsp_err  out  1  qualifies rsp_valid.
- busy  out  1  high when not in IDLE.

## Operation
- State machine: IDLE, SCAN, DECODE, CONSUME, ERR.
- **IDLE:**
  - req_ready=1.
  - On req_valid: capture sel and tag, clear stall_cnt.
  - If sel is illegal → ERR; otherwise → SCAN.
- **SCAN:**
  - lz = leading-zero count of bs_window, a priority search from bit 15.
  - If lz>7 or the window is all zeros → ERR. Codes longer than 15 bits are unsupported.
  - need = 2*lz+1, 5-bit.
  - If bs_avail ≥ need: register pos=lz → DECODE.
  - Otherwise: stall_cnt+1. Once stall_cnt == MAX_STALL while the bits are still short → ERR.
- **DECODE:**
  - Drive dec_sel=sel and dec_heading_one_pos=pos.
  - Register dec_output into rsp_data.
  - If dec_len ≠ 2*pos+1 → ERR; otherwise → CONSUME.
- **CONSUME:**
  - bs_consume=1, bs_consume_len=2*pos+1.
  - rsp_valid=1, rsp_err=0.
  - → IDLE.
- **ERR:**
  - rsp_valid=1, rsp_err=1, rsp_data=0.
  - No consume pulse.
  - → IDLE. The upper-level parser handles resync.
- **Reset values:** state=IDLE, req_ready=1, busy=0, all other outputs 0, stall_cnt=0.
- **Reset mid-operation:** return to IDLE on the next edge. No consume or response pulse is generated for the aborted request.
- **Requests while busy:** req_valid is ignored when not in IDLE. The requester holds it until req_ready is seen.

## Timing
- The request is accepted at edge 0, with IDLE, req_valid and req_ready all high.
- Best-case sequence:
  - SCAN in cycle 1.
  - DECODE in cycle 2.
  - CONSUME in cycle 3, with rsp_valid and bs_consume in the same cycle.
- Latency from acceptance to response: 3 cycles, plus stall cycles.
- Minimum issue interval: 4 cycles; req_ready returns in cycle 4.
- Illegal req_sel: ERR in cycle 1, rsp_valid with rsp_err.
- Window error detected in SCAN: rsp_err in cycle 2.
- Stall timeout: stall_cnt counts short cycles in SCAN; when it reaches MAX_STALL, the next cycle is ERR.
- bs_window and bs_avail are sampled only in SCAN and DECODE. The buffer may not shift between consume pulses.
- Outputs are registered except dec_sel and dec_heading_one_pos, which are decoded from state and pos.

## Test plan
- **ue, nominal:** req_sel=01, tag=5, window 16'h1400, avail=16 → dec_heading_one_pos=3; cycle 3 response: rsp_data=9, rsp_tag=5, bs_consume_len=7, one consume pulse.
- **ue, zero and back-to-back:** window 16'h8000 → rsp_data=0, len=1. A second request held on req_valid is accepted exactly 4 cycles after the first.
- **se, both signs:**
  - window 16'h3000 → rsp_data=3, len=5.
  - window 16'h2800 → rsp_data=8'hFE (-2), len=5.
- **Stall:**
  - window 16'h3000 with avail=4: busy remains high with no consume pulse.
  - Raise avail to 16 after 10 cycles → response of 3 follows 2 cycles later.
  - Repeat with avail held at 4: rsp_err=1 after MAX_STALL cycles, with no consume pulse.
- **Errors:**
  - window 16'h0000 → rsp_err=1, rsp_data=0, bs_consume never asserted.
  - req_sel=11 → rsp_err in cycle 1.
  - dec_len forced to a wrong value → rsp_err.
- **Reset:** assert reset during DECODE → state IDLE and req_ready=1 next cycle, with no rsp_valid and no bs_consume for that request.
